m4_mem_wctrl_fill: RTL

//  Parametrised M4 SRAM fill/clear write controller. Once armed, it walks every address of every bank,
//  one write per command cycle, and drives the write port of the M4 SRAM arbiter.

---
 rtl/m4_mem_fill_pkg.sv | 17 +
 rtl/m4_mem_fill_pattern.sv | 27 ++
 rtl/m4_mem_wctrl_fill.sv | 120 ++++++++++++
 3 files changed

// File: rtl/m4_mem_fill_pkg.sv
// Shared types for the M4 SRAM fill/clear write controller.
// State encoding and pattern mode codes.
package m4_mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_CONST = 2'b00;
  localparam logic [1:0] MODE_ADDR  = 2'b01;
  localparam logic [1:0] MODE_NADDR = 2'b10;
  localparam logic [1:0] MODE_ALT   = 2'b11;

endpackage

// File: rtl/m4_mem_fill_pattern.sv
// Combinational write-data pattern generator for the fill controller.
// Counter values are zero-extended or truncated to the data width.
module m4_mem_fill_pattern
  import m4_mem_fill_pkg::*;
#(
  parameter int CNT_W  = 20,
  parameter int DATA_W = 32
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic [DATA_W-1:0] seed,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] wdata
);

  // select pattern from the latched mode
  always_comb begin
    wdata = seed;
    unique case (mode)
      MODE_CONST: wdata = seed;
      MODE_ADDR:  wdata = DATA_W'(cnt);
      MODE_NADDR: wdata = DATA_W'(~cnt);
      MODE_ALT:   wdata = cnt[0] ? ~seed : seed;
      default:    wdata = seed;
    endcase
  end

endmodule

// File: rtl/m4_mem_wctrl_fill.sv
// M4 SRAM fill/clear write controller; walks every bank/address once.
// Optional data patterns enabled by defining M4_MEM_FILL_PATTERN_EN.
module m4_mem_wctrl_fill
  import m4_mem_fill_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int BANK_W = 1,
  parameter int DATA_W = 32,
  parameter int DQM_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cyc_stp,
  input  logic              cyc,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] wad,
  output logic [BANK_W-1:0] wbank,
  output logic              we,
  output logic [DQM_W-1:0]  dqm,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + BANK_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // sequencer: start qualification, address walk, abort and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      we    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      we <= cyc & (state == FILL) & start;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (cyc_stp && start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cyc_stp) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (!start) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cyc_stp) begin
            if (cnt == CNT_MAX) begin
              state <= DONE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wad   = cnt[ADDR_W-1:0];
  assign wbank = cnt[ADDR_W+:BANK_W];
  assign dqm   = '0;

`ifdef M4_MEM_FILL_PATTERN_EN
  logic [DATA_W-1:0] seed;
  logic [1:0]        mode_r;

  // latch pattern seed and mode on the ARM->FILL step
  always_ff @(posedge clk) begin
    if (rst) begin
      seed   <= '0;
      mode_r <= 2'b00;
    end else if (state == ARM && start && cyc_stp) begin
      seed   <= fill_value;
      mode_r <= mode;
    end
  end

  m4_mem_fill_pattern #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) u_pat (
    .cnt   (cnt),
    .seed  (seed),
    .mode  (mode_r),
    .wdata (wdata)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{fill_value, mode};
  assign wdata      = '0;
`endif

endmodule
